// File: rtl/philv_run_trace_if.sv
// Host/core-side signal bundle for the run controller and trace buffer.
interface philv_run_trace_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16,
  parameter int PTR_W = 6
);
  logic             start;
  logic [CNT_W-1:0] run_cycles;
  logic             halt;
  logic             bp_en;
  logic [XLEN-1:0]  bp_pc;
  logic [XLEN-1:0]  core_pc;
  logic [XLEN-1:0]  core_instr;
  logic [XLEN-1:0]  core_wb;
  logic             core_run;
  logic             busy;
  logic             done;
  logic [1:0]       stop_cause;
  logic [CNT_W-1:0] cycle_count;
  logic [PTR_W:0]   trace_count;
  logic             overflow;
  logic             rd_en;
  logic             rd_valid;
  logic [XLEN-1:0]  rd_pc;
  logic [XLEN-1:0]  rd_instr;
  logic [XLEN-1:0]  rd_wb;

  modport slave (
    input  start, run_cycles, halt, bp_en, bp_pc, core_pc, core_instr, core_wb, rd_en,
    output core_run, busy, done, stop_cause, cycle_count, trace_count, overflow,
           rd_valid, rd_pc, rd_instr, rd_wb
  );

  modport master (
    output start, run_cycles, halt, bp_en, bp_pc, core_pc, core_instr, core_wb, rd_en,
    input  core_run, busy, done, stop_cause, cycle_count, trace_count, overflow,
           rd_valid, rd_pc, rd_instr, rd_wb
  );
endinterface

// File: rtl/philv_run_trace_unit.sv
// Run controller: gates the core for a cycle budget, records {pc,instr,wb}
// into a circular trace each running cycle, then lets the host drain it.
module philv_run_trace_unit #(
  parameter int XLEN       = 32,
  parameter int DEPTH      = 64,
  parameter int CNT_W      = 16,
  parameter int MAX_CYCLES = 500,
  localparam int PTR_W     = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rstb,
  philv_run_trace_if.slave   bus
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  localparam logic [CNT_W-1:0] MAX_C  = CNT_W'(MAX_CYCLES);
  localparam logic [PTR_W:0]   FULL   = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_1  = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_1  = (PTR_W+1)'(1);
  localparam logic [CNT_W-1:0] CYC_1  = CNT_W'(1);
  localparam logic [CNT_W:0]   CYCW_1 = (CNT_W+1)'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] limit_q, limit_d;
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             ovf_q, ovf_d;
  logic [1:0]       cause_q, cause_d;
  logic             wr_en, rd_valid, do_start, bp_hit, lim_hit;

  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [XLEN-1:0] instr_mem [DEPTH];
  logic [XLEN-1:0] wb_mem    [DEPTH];

  assign rd_valid = (state_q == S_DONE) && (count_q != '0);
  // start is only honoured outside RUN; it wins over a same-cycle pop in DONE
  assign do_start = bus.start && (state_q != S_RUN);
  assign bp_hit   = bus.bp_en && (bus.core_pc == bus.bp_pc);
  // widened compare so a saturated counter cannot wrap into a false match
  assign lim_hit  = ({1'b0, cycle_q} + CYCW_1) == {1'b0, limit_q};

  always_comb begin
    state_d  = state_q;
    limit_d  = limit_q;
    cycle_d  = cycle_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    cause_d  = cause_q;
    wr_en    = 1'b0;
    case (state_q)
      S_RUN: begin
        wr_en    = 1'b1;
        wr_ptr_d = wr_ptr_q + PTR_1;
        if (count_q == FULL) begin
          rd_ptr_d = rd_ptr_q + PTR_1;
          ovf_d    = 1'b1;
        end else begin
          count_d  = count_q + CNT_1;
        end
        cycle_d = (&cycle_q) ? cycle_q : cycle_q + CYC_1;
        if (bp_hit) begin
          state_d = S_DONE;
          cause_d = 2'b10;
        end else if (bus.halt) begin
          state_d = S_DONE;
          cause_d = 2'b11;
        end else if (lim_hit) begin
          state_d = S_DONE;
          cause_d = 2'b01;
        end
      end
      S_DONE: begin
        if (bus.rd_en && rd_valid) begin
          rd_ptr_d = rd_ptr_q + PTR_1;
          count_d  = count_q - CNT_1;
        end
      end
      default: ;
    endcase
    if (do_start) begin
      state_d  = S_RUN;
      limit_d  = (bus.run_cycles == '0) ? MAX_C : bus.run_cycles;
      cycle_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
      cause_d  = 2'b00;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q  <= S_IDLE;
      limit_q  <= '0;
      cycle_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      cause_q  <= 2'b00;
    end else begin
      state_q  <= state_d;
      limit_q  <= limit_d;
      cycle_q  <= cycle_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      cause_q  <= cause_d;
    end
  end

  // Storage needs no reset: entries are only visible through count_q.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      pc_mem[wr_ptr_q]    <= bus.core_pc;
      instr_mem[wr_ptr_q] <= bus.core_instr;
      wb_mem[wr_ptr_q]    <= bus.core_wb;
    end
  end

  assign bus.core_run    = (state_q == S_RUN);
  assign bus.busy        = (state_q == S_RUN);
  assign bus.done        = (state_q == S_DONE);
  assign bus.stop_cause  = cause_q;
  assign bus.cycle_count = cycle_q;
  assign bus.trace_count = count_q;
  assign bus.overflow    = ovf_q;
  assign bus.rd_valid    = rd_valid;
  assign bus.rd_pc       = rd_valid ? pc_mem[rd_ptr_q]    : '0;
  assign bus.rd_instr    = rd_valid ? instr_mem[rd_ptr_q] : '0;
  assign bus.rd_wb       = rd_valid ? wb_mem[rd_ptr_q]    : '0;
endmodule

// File: tb/tb_philv_run_trace_unit.sv
// Directed bench: expected trace entries are queued per run and checked by a
// monitor on every pop; status outputs are checked against hand values.
module tb_philv_run_trace_unit;
  logic clk = 1'b0;
  logic rstb = 1'b0;
  always #5 clk = ~clk;

  philv_run_trace_if #(.XLEN(32), .CNT_W(16), .PTR_W(6)) bus();

  philv_run_trace_unit #(.XLEN(32), .DEPTH(64), .CNT_W(16), .MAX_CYCLES(500)) dut (
    .clk(clk), .rstb(rstb), .bus(bus)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] wb;
  } ent_t;

  ent_t        exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          run_idx = 0;
  logic        halt_mode = 1'b0;
  logic [31:0] halt_pc = '0;

  // Fake core: PC steps by 4 per running cycle; instr/wb derived from PC.
  assign bus.core_pc    = 32'(run_idx) * 32'd4;
  assign bus.core_instr = bus.core_pc ^ 32'hA5A5_0013;
  assign bus.core_wb    = bus.core_pc * 32'd3 + 32'h100;
  assign bus.halt       = halt_mode && bus.core_run && (bus.core_pc == halt_pc);

  always @(posedge clk or negedge rstb) begin
    if (!rstb)            run_idx <= 0;
    else if (bus.start)   run_idx <= 0;
    else if (bus.core_run) run_idx <= run_idx + 1;
  end

  function automatic ent_t exp_ent(int idx);
    ent_t e;
    e.pc    = 32'(idx * 4);
    e.instr = e.pc ^ 32'hA5A5_0013;
    e.wb    = e.pc * 32'd3 + 32'h100;
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: a pop happens on the next edge whenever rd_en && rd_valid and no start.
  always @(negedge clk) begin
    ent_t e;
    if (rstb && bus.rd_en && bus.rd_valid && !bus.start) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_pop: got pc %0h, expected no entry", bus.rd_pc);
      end else begin
        e = exp_q.pop_front();
        chk("rd_pc", 64'(bus.rd_pc), 64'(e.pc));
        chk("rd_instr", 64'(bus.rd_instr), 64'(e.instr));
        chk("rd_wb", 64'(bus.rd_wb), 64'(e.wb));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [15:0] cyc);
    bus.run_cycles = cyc;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int k = 0;
    while (!bus.done && k < bound) begin
      tick();
      k++;
    end
    chk("done_reached", 64'(bus.done), 64'd1);
  endtask

  task automatic push_range(input int first, input int last);
    for (int i = first; i <= last; i++) exp_q.push_back(exp_ent(i));
  endtask

  task automatic drain();
    int k = 0;
    bus.rd_en = 1'b1;
    while (bus.rd_valid && k < 100) begin
      tick();
      k++;
    end
    tick();  // pop with an empty buffer must be ignored
    bus.rd_en = 1'b0;
    chk("drain_rd_valid", 64'(bus.rd_valid), 64'd0);
    chk("drain_count", 64'(bus.trace_count), 64'd0);
    chk("drain_queue_left", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0; bus.run_cycles = '0; bus.bp_en = 1'b0; bus.bp_pc = '0; bus.rd_en = 1'b0;
    repeat (3) tick();
    chk("rst_core_run", 64'(bus.core_run), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_rd_valid", 64'(bus.rd_valid), 64'd0);
    rstb = 1'b1;
    tick();
    chk("idle_status", {bus.busy, bus.done, bus.stop_cause, bus.cycle_count, bus.trace_count, bus.overflow}, 64'd0);

    // 1: limit of 5
    do_start(16'd5);
    chk("t1_busy", 64'(bus.busy), 64'd1);
    wait_done(20);
    chk("t1_runlen", 64'(run_idx), 64'd5);
    chk("t1_cause", 64'(bus.stop_cause), 64'd1);
    chk("t1_cycles", 64'(bus.cycle_count), 64'd5);
    chk("t1_count", 64'(bus.trace_count), 64'd5);
    chk("t1_first_pc", 64'(bus.rd_pc), 64'h0);
    push_range(0, 4);
    drain();

    // 2: default budget with wrap-around
    do_start(16'd0);
    wait_done(600);
    chk("t2_runlen", 64'(run_idx), 64'd500);
    chk("t2_cause", 64'(bus.stop_cause), 64'd1);
    chk("t2_cycles", 64'(bus.cycle_count), 64'd500);
    chk("t2_count", 64'(bus.trace_count), 64'd64);
    chk("t2_overflow", 64'(bus.overflow), 64'd1);
    chk("t2_first_pc", 64'(bus.rd_pc), 64'h6D0);
    push_range(436, 499);
    drain();
    chk("t2_ovf_sticky", 64'(bus.overflow), 64'd1);

    // 3: breakpoint at 0xC beats a simultaneous halt
    bus.bp_en = 1'b1; bus.bp_pc = 32'hC;
    halt_mode = 1'b1; halt_pc = 32'hC;
    do_start(16'd100);
    chk("t3_ovf_cleared", 64'(bus.overflow), 64'd0);
    wait_done(20);
    chk("t3_cause", 64'(bus.stop_cause), 64'd2);
    chk("t3_count", 64'(bus.trace_count), 64'd4);
    chk("t3_cycles", 64'(bus.cycle_count), 64'd4);
    push_range(0, 3);
    drain();
    bus.bp_en = 1'b0;

    // 4: halt in cycle 3, rd_en held during RUN
    halt_pc = 32'h8;
    do_start(16'd10);
    bus.rd_en = 1'b1;
    wait_done(20);
    bus.rd_en = 1'b0;
    halt_mode = 1'b0;
    chk("t4_cause", 64'(bus.stop_cause), 64'd3);
    chk("t4_cycles", 64'(bus.cycle_count), 64'd3);
    chk("t4_count", 64'(bus.trace_count), 64'd3);
    push_range(0, 2);
    drain();

    // 5: partial drain then start with simultaneous rd_en
    do_start(16'd4);
    wait_done(20);
    push_range(0, 1);
    bus.rd_en = 1'b1;
    tick(); tick();
    bus.rd_en = 1'b0;
    chk("t5_count_after_pop", 64'(bus.trace_count), 64'd2);
    chk("t5_head_pc", 64'(bus.rd_pc), 64'h8);
    bus.start = 1'b1; bus.rd_en = 1'b1;
    tick();
    bus.start = 1'b0; bus.rd_en = 1'b0;
    chk("t5_restart_busy", 64'(bus.busy), 64'd1);
    chk("t5_restart_count", 64'(bus.trace_count), 64'd0);
    chk("t5_restart_ovf", 64'(bus.overflow), 64'd0);
    wait_done(20);
    chk("t5_count", 64'(bus.trace_count), 64'd4);
    push_range(0, 3);
    drain();

    // 6: async reset mid-RUN and mid-drain
    do_start(16'd10);
    tick(); tick();
    #2 rstb = 1'b0;
    #1;
    chk("t6a_core_run", 64'(bus.core_run), 64'd0);
    chk("t6a_count", 64'(bus.trace_count), 64'd0);
    tick();
    rstb = 1'b1;
    tick();
    chk("t6a_idle", {bus.busy, bus.done, bus.cycle_count}, 64'd0);
    do_start(16'd5);
    wait_done(20);
    push_range(0, 0);
    bus.rd_en = 1'b1;
    tick();
    #2 rstb = 1'b0;
    bus.rd_en = 1'b0;
    #1;
    chk("t6b_done", 64'(bus.done), 64'd0);
    chk("t6b_rd_valid", 64'(bus.rd_valid), 64'd0);
    chk("t6b_count", 64'(bus.trace_count), 64'd0);
    tick();
    rstb = 1'b1;
    tick();
    chk("t6b_idle", {bus.busy, bus.done, bus.stop_cause, bus.overflow}, 64'd0);
    chk("t6b_queue_left", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/philv_run_trace_unit.md
Name: philv_run_trace_unit

Overview:
Synthesisable run controller and trace capture for the Philosophy V core. It gates core execution for a programmable cycle budget. Each running cycle it records {PC, instruction, WB value} into a circular trace buffer. It stops on cycle limit, PC breakpoint or external halt, then lets a host drain the trace oldest-first. It sits beside philosophy_v_core, driving its run enable and sampling its IF/instr/WB signals.

Parameters:
XLEN, 32, width of PC, instruction and WB fields
DEPTH, 64, trace entries; power of two, >=2; PTR_W = $clog2(DEPTH)
CNT_W, 16, width of cycle budget and cycle counter
MAX_CYCLES, 500, budget used when run_cycles==0

Ports:
clk  in  1  clock, all state updates on rising edge
rstb  in  1  asynchronous active-low reset
start  in  1  begin new run (pulse)
run_cycles  in  CNT_W  cycle budget; 0 selects MAX_CYCLES
halt  in  1  external stop request
bp_en  in  1  enable PC breakpoint
bp_pc  in  XLEN  breakpoint PC
core_pc  in  XLEN  current PC from core
core_instr  in  XLEN  current instruction from core
core_wb  in  XLEN  current WB value from core
core_run  out  1  run enable to core
busy  out  1  high in RUN
done  out  1  high in DONE
stop_cause  out  2  00 none, 01 limit, 10 breakpoint, 11 halt
cycle_count  out  CNT_W  cycles executed in current/last run
trace_count  out  PTR_W+1  valid entries in buffer (0..DEPTH)
overflow  out  1  sticky; oldest entries were overwritten
rd_en  in  1  pop oldest entry
rd_valid  out  1  oldest entry available
rd_pc, rd_instr, rd_wb  out  XLEN each  oldest entry fields

Behaviour:
- Reset (rstb low, async): state IDLE, all outputs 0, pointers/count 0, overflow 0, stop_cause 00, cycle_count 0.
- States: IDLE, RUN, DONE. core_run = busy = (state==RUN); done = (state==DONE).
- IDLE: start=1 enters RUN next cycle. On that edge: limit latched (run_cycles, or MAX_CYCLES if 0), cycle_count=0, buffer emptied, overflow=0, stop_cause=00.
- RUN, every cycle:
  - Write {core_pc, core_instr, core_wb} at wr_ptr; wr_ptr++ (wraps mod DEPTH).
  - If count==DEPTH, rd_ptr++ as well (oldest overwritten), count unchanged, overflow<=1. Otherwise count++.
  - cycle_count++ (saturates at all-ones).
- RUN stop evaluation uses the same-cycle sample, and the sampled entry is always recorded. Priority: breakpoint (bp_en && core_pc==bp_pc) -> 10; else halt -> 11; else (cycle_count+1 == limit) -> 01.
- On any stop condition: next state DONE, stop_cause latched. A run of limit L therefore records exactly L entries and cycle_count ends at L.
- start during RUN is ignored.
- DONE:
  - rd_valid = (count!=0). rd_* show the entry at rd_ptr combinationally.
  - rd_en && rd_valid: rd_ptr++, count-- on the edge. rd_en with count==0 is ignored.
  - start=1 re-enters RUN with the same initialisation as from IDLE. start has priority over a simultaneous rd_en (the pop is discarded).
- rd_valid is 0 outside DONE; rd_en is ignored outside DONE.
- stop_cause, cycle_count and overflow hold in DONE until the next start.
- Reset asserted mid-RUN or mid-drain returns to IDLE immediately with all state cleared; no partial trace is retained.

Test Plan:
- Reset, start with run_cycles=5, bp_en=0, core_pc stepping 0x0,0x4,... -> core_run high exactly 5 cycles; DONE, stop_cause=01, cycle_count=5, trace_count=5; draining yields PCs 0x0..0x10 in order, then rd_valid=0.
- run_cycles=0 -> run lasts MAX_CYCLES=500 cycles; trace_count=64, overflow=1; first drained PC is the sample from cycle 437 (0x6D0), last is cycle 500 (0x7CC).
- bp_en=1, bp_pc=0xC, run_cycles=100 -> stops after 4 cycles; stop_cause=10, trace_count=4, last entry PC=0xC. With halt also asserted in that cycle, stop_cause is still 10.
- halt pulsed in cycle 3 of a 10-cycle run -> stop_cause=11, cycle_count=3; rd_en held during RUN has no effect.
- In DONE with 4 entries, pop 2, then assert start together with rd_en -> RUN; trace_count restarts from 0 and overflow=0.
- Assert rstb low mid-RUN and mid-drain -> core_run, done and rd_valid drop to 0 without waiting for a clock edge; trace_count=0, state IDLE.
